// File: rtl/gam_winner_search.sv
// -----------------------------------------------------------------------------
// gam_winner_search
//   Scans NODE_COUNT weight vectors of one class. For each node it computes the
//   L1 distance to the input vector and tracks the nearest node (win1) and,
//   optionally, the second-nearest node (win2).
//
//   Search flow: IDLE -> SCAN (one weight read per cycle, indices 1..NODE_COUNT)
//   -> DRAIN (last weight arrives) -> DONE (one-cycle done pulse) -> IDLE.
//   done rises NODE_COUNT+2 cycles after the accepting start cycle.
//
//   Optional feature macro: GAM_SECOND_WINNER_EN
//     defined   : win2_idx / win2_dist ports and second-winner tracking exist
//     undefined : only win1 is tracked (win1 behaviour is identical)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   search request, accepted only in IDLE
//   x            in   input vector, element k at [k*PIXEL_W +: PIXEL_W]
//   node_valid   in   bit i-1 set -> node i takes part in the search
//   node_rd_en   out  weight read strobe
//   node_rd_idx  out  node index being read (1..NODE_COUNT, 0 when idle)
//   node_rd_w    in   weight vector, returned one cycle after node_rd_en
//   busy         out  search in progress (SCAN and DRAIN)
//   done         out  one-cycle completion pulse
//   found        out  at least one valid node was scanned
//   win1_idx/dist out nearest node index and distance
//   win2_idx/dist out second-nearest node index and distance (macro only)
// -----------------------------------------------------------------------------
module gam_winner_search #(
    parameter int NODE_COUNT = 10,
    parameter int VECTOR_LEN = 4,
    parameter int PIXEL_W    = 8,
    localparam int IDX_W     = $clog2(NODE_COUNT + 1),
    localparam int DIST_W    = PIXEL_W + $clog2(VECTOR_LEN) + 1,
    localparam int VEC_W     = VECTOR_LEN * PIXEL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VEC_W-1:0]      x,
    input  logic [NODE_COUNT-1:0] node_valid,
    output logic                  node_rd_en,
    output logic [IDX_W-1:0]      node_rd_idx,
    input  logic [VEC_W-1:0]      node_rd_w,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [IDX_W-1:0]      win1_idx,
    output logic [DIST_W-1:0]     win1_dist
`ifdef GAM_SECOND_WINNER_EN
    ,
    output logic [IDX_W-1:0]      win2_idx,
    output logic [DIST_W-1:0]     win2_dist
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NODE_COUNT);
    localparam logic [DIST_W-1:0] DIST_MAX = {DIST_W{1'b1}};

    // L1 distance; DIST_W leaves a spare bit so VECTOR_LEN*(2^PIXEL_W-1) always fits
    function automatic logic [DIST_W-1:0] l1_dist(input logic [VEC_W-1:0] a,
                                                  input logic [VEC_W-1:0] b);
        logic [DIST_W-1:0]  acc;
        logic [PIXEL_W-1:0] ea;
        logic [PIXEL_W-1:0] eb;
        acc = {DIST_W{1'b0}};
        for (int k = 0; k < VECTOR_LEN; k++) begin
            ea = a[k*PIXEL_W +: PIXEL_W];
            eb = b[k*PIXEL_W +: PIXEL_W];
            if (ea > eb) begin
                acc = acc + DIST_W'(ea - eb);
            end else begin
                acc = acc + DIST_W'(eb - ea);
            end
        end
        return acc;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic                  accept_s;
    logic                  rd_en_r;
    logic [IDX_W-1:0]      rd_idx_r;
    logic                  busy_r;
    logic                  done_r;
    logic [VEC_W-1:0]      x_lat_r;
    logic [NODE_COUNT-1:0] valid_lat_r;
    logic                  arr_valid_r;
    logic [IDX_W-1:0]      arr_idx_r;
    logic                  hit_s;
    logic [DIST_W-1:0]     dist_s;
    logic                  found_r;
    logic [IDX_W-1:0]      win1_idx_r;
    logic [DIST_W-1:0]     win1_dist_r;
`ifdef GAM_SECOND_WINNER_EN
    logic [IDX_W-1:0]      win2_idx_r;
    logic [DIST_W-1:0]     win2_dist_r;
`endif

    assign accept_s = (state_r == ST_IDLE) && start;

    // Next-state logic of the search sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (rd_idx_r == IDX_LAST) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DRAIN: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state plus registered read strobe/index and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            rd_en_r  <= 1'b0;
            rd_idx_r <= IDX_ZERO;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rd_en_r <= (state_nxt_s == ST_SCAN);
            busy_r  <= (state_nxt_s == ST_SCAN) || (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                rd_idx_r <= IDX_ONE;
            end else if ((state_r == ST_SCAN) && (rd_idx_r != IDX_LAST)) begin
                rd_idx_r <= rd_idx_r + IDX_ONE;
            end else begin
                rd_idx_r <= IDX_ZERO;
            end
        end
    end

    // Capture x and node_valid on the accepting start so later changes are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_lat_r     <= {VEC_W{1'b0}};
            valid_lat_r <= {NODE_COUNT{1'b0}};
        end else if (accept_s) begin
            x_lat_r     <= x;
            valid_lat_r <= node_valid;
        end
    end

    // Track which node's weight is arriving on node_rd_w this cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arr_valid_r <= 1'b0;
            arr_idx_r   <= IDX_ZERO;
        end else begin
            arr_valid_r <= rd_en_r;
            arr_idx_r   <= rd_idx_r;
        end
    end

    // Arriving node takes part only if its latched valid bit is set
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < NODE_COUNT; i++) begin
            hit_s = hit_s | (arr_valid_r & valid_lat_r[i] & (arr_idx_r == IDX_W'(i + 1)));
        end
    end

    assign dist_s = l1_dist(x_lat_r, node_rd_w);

    // Winner insertion; strict less-than keeps the lower index on ties
    always_ff @(posedge clk) begin
        if (!rst_n || accept_s) begin
            found_r     <= 1'b0;
            win1_idx_r  <= IDX_ZERO;
            win1_dist_r <= DIST_MAX;
`ifdef GAM_SECOND_WINNER_EN
            win2_idx_r  <= IDX_ZERO;
            win2_dist_r <= DIST_MAX;
`endif
        end else if (hit_s) begin
            found_r <= 1'b1;
            if (dist_s < win1_dist_r) begin
`ifdef GAM_SECOND_WINNER_EN
                win2_idx_r  <= win1_idx_r;
                win2_dist_r <= win1_dist_r;
`endif
                win1_idx_r  <= arr_idx_r;
                win1_dist_r <= dist_s;
            end
`ifdef GAM_SECOND_WINNER_EN
            else if (dist_s < win2_dist_r) begin
                win2_idx_r  <= arr_idx_r;
                win2_dist_r <= dist_s;
            end
`endif
        end
    end

    assign node_rd_en  = rd_en_r;
    assign node_rd_idx = rd_idx_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign found       = found_r;
    assign win1_idx    = win1_idx_r;
    assign win1_dist   = win1_dist_r;
`ifdef GAM_SECOND_WINNER_EN
    assign win2_idx    = win2_idx_r;
    assign win2_dist   = win2_dist_r;
`endif

endmodule

// File: tb/tb_gam_winner_search.sv
// -----------------------------------------------------------------------------
// tb_gam_winner_search
//   Self-checking bench for gam_winner_search (NODE_COUNT=10, VECTOR_LEN=4,
//   PIXEL_W=8). A weight memory answers reads one cycle after node_rd_en.
//   Checks cover the reset state, a table of directed searches, overlapping
//   start / input changes, reset mid-search and random searches compared
//   against a ranking model. win2 checks exist when GAM_SECOND_WINNER_EN is set.
// -----------------------------------------------------------------------------
module tb_gam_winner_search;

    localparam int N      = 10;
    localparam int VL     = 4;
    localparam int PW     = 8;
    localparam int IDX_W  = 4;
    localparam int DIST_W = 11;
    localparam int XW     = VL * PW;
    localparam int DMAX   = 2047;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [XW-1:0]     x;
    logic [N-1:0]      node_valid;
    logic              node_rd_en;
    logic [IDX_W-1:0]  node_rd_idx;
    logic [XW-1:0]     node_rd_w = '0;
    logic              busy;
    logic              done;
    logic              found;
    logic [IDX_W-1:0]  win1_idx;
    logic [DIST_W-1:0] win1_dist;
`ifdef GAM_SECOND_WINNER_EN
    logic [IDX_W-1:0]  win2_idx;
    logic [DIST_W-1:0] win2_dist;
`endif

    logic [XW-1:0] mem [0:N];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [XW-1:0] xv;
        logic [N-1:0]  vv;
        int            mode;
        int            found;
        int            w1i;
        int            w1d;
        int            w2i;
        int            w2d;
    } vec_t;

    vec_t tbl [6];

    gam_winner_search #(.NODE_COUNT(N), .VECTOR_LEN(VL), .PIXEL_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x           (x),
        .node_valid  (node_valid),
        .node_rd_en  (node_rd_en),
        .node_rd_idx (node_rd_idx),
        .node_rd_w   (node_rd_w),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .win1_idx    (win1_idx),
        .win1_dist   (win1_dist)
`ifdef GAM_SECOND_WINNER_EN
        ,
        .win2_idx    (win2_idx),
        .win2_dist   (win2_dist)
`endif
    );

    always #5 clk = ~clk;

    // weight memory: data one cycle after the read strobe
    always @(posedge clk) begin
        if (node_rd_en) node_rd_w <= mem[node_rd_idx];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mode 0: node i = i*10 everywhere; 1: all zero; 2: random wide; 3: random coarse (ties)
    task automatic set_mem(input int mode);
        for (int i = 0; i <= N; i++) begin
            for (int k = 0; k < VL; k++) begin
                case (mode)
                    0: mem[i][k*PW +: PW] = 8'(i * 10);
                    1: mem[i][k*PW +: PW] = 8'd0;
                    2: mem[i][k*PW +: PW] = 8'($urandom_range(0, 255));
                    default: mem[i][k*PW +: PW] = 8'($urandom_range(0, 3) * 85);
                endcase
            end
        end
    endtask

    // Reference: rank valid nodes by (distance, index) and take the first two
    function automatic vec_t model(input logic [XW-1:0] xv, input logic [N-1:0] vv);
        vec_t r;
        int d [1:N];
        int b1, b2, a, w;
        r.xv = xv; r.vv = vv; r.mode = 2;
        r.found = 0; r.w1i = 0; r.w1d = DMAX; r.w2i = 0; r.w2d = DMAX;
        b1 = 0; b2 = 0;
        for (int i = 1; i <= N; i++) begin
            d[i] = 0;
            for (int k = 0; k < VL; k++) begin
                a = int'(xv[k*PW +: PW]);
                w = int'(mem[i][k*PW +: PW]);
                d[i] += (a > w) ? a - w : w - a;
            end
        end
        for (int i = 1; i <= N; i++)
            if (vv[i-1] && (b1 == 0 || d[i] < d[b1])) b1 = i;
        for (int i = 1; i <= N; i++)
            if (vv[i-1] && i != b1 && (b2 == 0 || d[i] < d[b2])) b2 = i;
        if (b1 != 0) begin r.found = 1; r.w1i = b1; r.w1d = d[b1]; end
        if (b2 != 0) begin r.w2i = b2; r.w2d = d[b2]; end
        return r;
    endfunction

    // One search; disturb pulses a second start and scrambles inputs mid-scan
    task automatic run_search(input vec_t e, input bit disturb, input string tag);
        int done_at, done_cnt, rd_cnt, idx_bad;
        logic [31:0] c_found, c_w1i, c_w1d, c_w2i, c_w2d;
        c_found = 'x; c_w1i = 'x; c_w1d = 'x; c_w2i = 'x; c_w2d = 'x;
        @(negedge clk);
        x = e.xv; node_valid = e.vv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_at = -1; done_cnt = 0; rd_cnt = 0; idx_bad = 0;
        for (int k = 1; k <= N + 6; k++) begin
            if (disturb && k == 3) begin
                start = 1'b1; x = ~e.xv; node_valid = ~e.vv;
            end
            if (disturb && k == 4) start = 1'b0;
            if (k == 1) check({tag, "_busy_first"}, 32'(busy), 32'd1);
            if (k == N + 1) check({tag, "_busy_drain"}, 32'(busy), 32'd1);
            if (node_rd_en) begin
                rd_cnt++;
                if (int'(node_rd_idx) != rd_cnt) idx_bad++;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    c_found = 32'(found); c_w1i = 32'(win1_idx); c_w1d = 32'(win1_dist);
`ifdef GAM_SECOND_WINNER_EN
                    c_w2i = 32'(win2_idx); c_w2d = 32'(win2_dist);
`endif
                end
            end
            @(negedge clk);
        end
        check({tag, "_done_latency"}, 32'(done_at), 32'(N + 2));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_read_count"}, 32'(rd_cnt), 32'(N));
        check({tag, "_read_order"}, 32'(idx_bad), 32'd0);
        check({tag, "_found"}, c_found, 32'(e.found));
        check({tag, "_win1_idx"}, c_w1i, 32'(e.w1i));
        check({tag, "_win1_dist"}, c_w1d, 32'(e.w1d));
        check({tag, "_win1_dist_hold"}, 32'(win1_dist), 32'(e.w1d));
`ifdef GAM_SECOND_WINNER_EN
        check({tag, "_win2_idx"}, c_w2i, 32'(e.w2i));
        check({tag, "_win2_dist"}, c_w2d, 32'(e.w2d));
`endif
    endtask

    initial begin
        logic [XW-1:0] x35, x255, x0;
        logic [N-1:0]  all_v;
        vec_t          rv;
        int            cnt;
        x35 = {4{8'd35}}; x255 = {4{8'd255}}; x0 = '0; all_v = '1;

        tbl[0] = '{xv: x35,  vv: all_v,          mode: 0, found: 1, w1i: 3, w1d: 20,   w2i: 4, w2d: 20};
        tbl[1] = '{xv: x35,  vv: 10'b1111111011, mode: 0, found: 1, w1i: 4, w1d: 20,   w2i: 2, w2d: 60};
        tbl[2] = '{xv: x35,  vv: 10'b0,          mode: 0, found: 0, w1i: 0, w1d: DMAX, w2i: 0, w2d: DMAX};
        tbl[3] = '{xv: x35,  vv: 10'b0000100000, mode: 0, found: 1, w1i: 6, w1d: 100,  w2i: 0, w2d: DMAX};
        tbl[4] = '{xv: x255, vv: all_v,          mode: 1, found: 1, w1i: 1, w1d: 1020, w2i: 2, w2d: 1020};
        tbl[5] = '{xv: x0,   vv: all_v,          mode: 0, found: 1, w1i: 1, w1d: 40,   w2i: 2, w2d: 80};

        // reset with a coincident start request
        rst_n = 1'b0; start = 1'b1; x = x35; node_valid = all_v;
        set_mem(0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(node_rd_en), 32'd0);
        check("rst_rd_idx", 32'(node_rd_idx), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_win1_idx", 32'(win1_idx), 32'd0);
        check("rst_win1_dist", 32'(win1_dist), 32'(DMAX));
`ifdef GAM_SECOND_WINNER_EN
        check("rst_win2_idx", 32'(win2_idx), 32'd0);
        check("rst_win2_dist", 32'(win2_dist), 32'(DMAX));
`endif
        rst_n = 1'b1; start = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (node_rd_en || busy || done) cnt++;
        end
        check("start_in_reset_ignored", 32'(cnt), 32'd0);

        for (int t = 0; t < 6; t++) begin
            set_mem(tbl[t].mode);
            run_search(tbl[t], 1'b0, $sformatf("tbl%0d", t));
        end

        // overlap: second start and input changes during SCAN
        set_mem(0);
        run_search(tbl[0], 1'b1, "overlap");

        // reset at the 5th SCAN cycle
        @(negedge clk);
        x = x35; node_valid = all_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rd_en", 32'(node_rd_en), 32'd0);
        check("abort_rd_idx", 32'(node_rd_idx), 32'd0);
        check("abort_found", 32'(found), 32'd0);
        check("abort_win1_idx", 32'(win1_idx), 32'd0);
        check("abort_win1_dist", 32'(win1_dist), 32'(DMAX));
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_search(tbl[0], 1'b0, "after_abort");

        // random searches against the ranking model
        for (int r = 0; r < 20; r++) begin
            set_mem((r % 2 == 0) ? 2 : 3);
            x = XW'($urandom);
            if (r % 2 == 1) x = {4{8'($urandom_range(0, 3) * 85)}};
            node_valid = N'($urandom);
            if (r % 5 == 0) node_valid = N'($urandom & $urandom & $urandom);
            rv = model(x, node_valid);
            run_search(rv, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
